dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
Parametrised, pipelined data memory with a load/store front end for the RV32 core's MEM stage. It accepts one byte-addressed load or store per cycle over a valid/ready handshake. Store data is lane-shifted and byte-masked. Load data is lane-extracted and sign- or zero-extended. Each request returns an in-order response after a fixed, configurable latency. It replaces the combinational-read, word-addressed data RAM with a synchronous, pipelined one that flags misaligned accesses.

Parameters:
ADDR_BITS, 16, word-address bits; the memory holds 2**ADDR_BITS 32-bit words.
LATENCY, 2, cycles from request acceptance to response; legal range 1..8.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_BITS+2  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response valid, one-cycle pulse per request
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal-size request
busy  out  1  at least one request in flight
err_cnt  out  ERR_CNT_W  saturating count of errored requests

Behaviour:
- Reset (asynchronous):
  - req_ready=0 while rst_n=0, then 1 from the first cycle after deassertion.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, err_cnt=0.
  - All pipeline valid bits are cleared; in-flight requests are dropped and produce no response.
  - Memory contents are NOT reset: zero at simulation start, otherwise retained.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - There is no response backpressure, so req_ready stays 1 outside reset and throughput is 1 request/cycle.
- Latency: a request accepted at edge N produces rsp_valid=1 for exactly the cycle following edge N+LATENCY-1. For LATENCY=1, the response is visible in the cycle after acceptance. Responses return in acceptance order.
- Addressing: word index = req_addr[ADDR_BITS+1:2]; lane = req_addr[1:0].
- Alignment error when either:
  - size=1 with addr[0]=1;
  - size=2 with addr[1:0]!=0;
  - or size=3 for any address.
  - An errored store writes nothing. An errored load returns rdata=0. rsp_err=1 on that request's response. err_cnt increments at acceptance and saturates at all-ones.
- Stores:
  - Byte: write enable = 1<<lane, data = wdata[7:0] replicated to all lanes.
  - Half: write enable = 2'b11<<lane, data = wdata[15:0] replicated to both halves.
  - Word: write enable = 4'hF.
  - The memory write commits at the acceptance edge. The store response has rdata=0, err=0.
- Loads:
  - The memory word is sampled at the acceptance edge and carried down the pipeline with lane, size and unsigned flags.
  - Extraction and extension are applied at the output stage.
  - Byte: bits [8*lane+7 : 8*lane]. Half: bits [8*lane+15 : 8*lane]. Both are extended per req_unsigned. Word: passed through unchanged.
- Hazards:
  - A load accepted at an edge after a store's acceptance edge sees the store's data.
  - A load is never affected by a store accepted at a later edge, even one that commits before the load's response.
- busy: 1 whenever any pipeline stage holds a valid request, excluding the output register. It is combinational from the stage valid bits.
- Simultaneous events: reset overrides everything. A request with req_valid while rst_n=0 is ignored.

Test Plan:
- Word store then load: store 0xDEADBEEF to addr 0x0010; next cycle load word from 0x0010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, exactly LATENCY cycles after the load is accepted.
- Byte/half extension: store word 0x80F17F02 to 0x20; then:
  - lb 0x21 -> 0x0000007F;
  - lb 0x23 -> 0xFFFFFF80;
  - lbu 0x23 -> 0x00000080;
  - lh 0x22 -> 0xFFFF80F1;
  - lhu 0x22 -> 0x000080F1.
- Partial store: word 0 = 0x11223344; sb 0xAA to addr 0x2, then load word 0 -> 0x11AA3344; sh 0xBEEF to addr 0x0, then load word 0 -> 0x11AABEEF.
- Misaligned: lw 0x5, sh 0x3, size=3 at 0x0 -> three responses with rsp_err=1, rdata=0, err_cnt=3; a word at 0x4 is unchanged after the errored sh.
- Back-to-back with LATENCY=3: 6 consecutive loads of words 0..5 preloaded with 0..5 -> 6 consecutive rsp_valid cycles starting 3 cycles after the first accept, data 0..5 in order, busy high throughout. Also, a store to word 1 accepted right after the load of word 1 -> that load still returns 1.
- Reset mid-flight: with LATENCY=4, accept 2 loads, then pulse rst_n low for 1 cycle asynchronously (not edge-aligned) -> no rsp_valid follows, busy=0 and err_cnt=0 immediately, memory contents preserved on a subsequent load.

Source files
------------

// File: rtl/dmem_lsu.sv
// Pipelined byte-addressed data memory with load/store lane handling for the MEM stage.
// Requests are accepted one per cycle; responses return in order after LATENCY cycles.
module dmem_lsu #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_BITS+1:0]   req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  typedef struct packed {
    logic        we;
    logic        err;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] word;
  } stage_t;

  logic [31:0]          mem [2**ADDR_BITS];
  logic                 ready_q;
  logic [LATENCY-1:0]   valid_q;
  stage_t               pipe_q [LATENCY];
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 accept;
  logic                 req_err;
  logic [3:0]           be;
  logic [31:0]          wdata_rep;
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;

  assign accept   = req_valid & ready_q;
  assign word_idx = req_addr[ADDR_BITS+1:2];
  assign lane     = req_addr[1:0];

  always_comb begin
    req_err   = 1'b0;
    be        = 4'h0;
    wdata_rep = req_wdata;
    case (req_size)
      2'd0: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_err   = lane[0];
        be        = 4'b0011 << lane;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        req_err = |lane;
        be      = 4'hF;
      end
      default: req_err = 1'b1;
    endcase
  end

  // Memory is deliberately not reset; stores commit at their acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Payload samples the word before any same-edge write, so later stores never leak in.
  always_ff @(posedge clk) begin
    pipe_q[0] <= '{we: req_we, err: req_err, size: req_size, uns: req_unsigned,
                   lane: lane, word: mem[word_idx]};
    for (int unsigned k = 1; k < LATENCY; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      valid_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      ready_q    <= 1'b1;
      valid_q[0] <= accept;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      if (accept && req_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k + 1 < LATENCY; k++) begin
      busy = busy | valid_q[k];
    end
  end

  stage_t      last;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign last = pipe_q[LATENCY-1];

  always_comb begin
    ld_byte = last.word[7:0];
    case (last.lane)
      2'd0: ld_byte = last.word[7:0];
      2'd1: ld_byte = last.word[15:8];
      2'd2: ld_byte = last.word[23:16];
      default: ld_byte = last.word[31:24];
    endcase
    ld_half = last.lane[1] ? last.word[31:16] : last.word[15:0];
    case (last.size)
      2'd0:    ld_ext = {{24{~last.uns & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{~last.uns & ld_half[15]}}, ld_half};
      default: ld_ext = last.word;
    endcase
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q[LATENCY-1];
  assign rsp_err   = valid_q[LATENCY-1] & last.err;
  assign rsp_rdata = (valid_q[LATENCY-1] && !last.we && !last.err) ? ld_ext : 32'h0;
  assign err_cnt   = err_cnt_q;

endmodule
